// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: collects an 8-slot frame into a shadow
// buffer and presents all eight channels together once the frame completes.
module tdm_demux8 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [WIDTH-1:0] ch4,
  output logic [WIDTH-1:0] ch5,
  output logic [WIDTH-1:0] ch6,
  output logic [WIDTH-1:0] ch7,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [2:0]       slot,
  output logic             busy
);

  localparam int unsigned NSLOT  = 8;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  // Slot 7 goes straight to the channel register, so only slots 0..6 are shadowed.
  logic [WIDTH-1:0]    shadow_q [NSLOT-1];
  logic [WIDTH-1:0]    shadow_d [NSLOT-1];
  logic [WIDTH-1:0]    ch_q     [NSLOT];
  logic [WIDTH-1:0]    ch_d     [NSLOT];
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  // Next-state, slot steering and frame publication.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_d          = ch_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (din_valid) begin
      if (state_q == IDLE) begin
        if (sof) begin
          shadow_d[0] = din;
          slot_d      = SLOT_W'(1);
          state_d     = COLLECT;
        end
      end else begin
        if (sof) begin
          // Early sof: abandon the partial frame and restart at slot 0.
          frame_err_d = 1'b1;
          shadow_d[0] = din;
          slot_d      = SLOT_W'(1);
        end else if (slot_q == SLOT_W'(NSLOT - 1)) begin
          for (int unsigned i = 0; i < NSLOT - 1; i++) begin
            ch_d[i] = shadow_q[i];
          end
          ch_d[NSLOT-1] = din;
          frame_valid_d = 1'b1;
          slot_d        = '0;
          state_d       = IDLE;
        end else begin
          for (int unsigned i = 1; i < NSLOT - 1; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              shadow_d[i] = din;
            end
          end
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    end

    busy_d = (state_d == COLLECT);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      for (int unsigned i = 0; i < NSLOT - 1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NSLOT; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
      shadow_q      <= shadow_d;
      ch_q          <= ch_d;
    end
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign ch4         = ch_q[4];
  assign ch5         = ch_q[5];
  assign ch6         = ch_q[6];
  assign ch7         = ch_q[7];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign slot        = slot_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed scenarios plus random traffic, checked every
// cycle against a frame-level queue model.
module tb_tdm_demux8;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] ch [8];
  logic         frame_valid, frame_err, busy;
  logic [2:0]   slot;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .ch0(ch[0]), .ch1(ch[1]), .ch2(ch[2]), .ch3(ch[3]),
    .ch4(ch[4]), .ch5(ch[5]), .ch6(ch[6]), .ch7(ch[7]),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .slot(slot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // Frame-level model: words collected so far, last published frame, pulses.
  logic [W-1:0] m_words [$];
  bit           m_in  = 1'b0;
  logic [W-1:0] m_ch [8] = '{default: '0};
  bit           m_fv  = 1'b0;
  bit           m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_words.delete();
      m_in  = 1'b0;
      m_fv  = 1'b0;
      m_err = 1'b0;
      foreach (m_ch[i]) m_ch[i] = '0;
    end else begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (din_valid) begin
        if (sof) begin
          if (m_in) m_err = 1'b1;
          m_words.delete();
          m_words.push_back(din);
          m_in = 1'b1;
        end else if (m_in) begin
          m_words.push_back(din);
          if (m_words.size() == 8) begin
            foreach (m_ch[i]) m_ch[i] = m_words[i];
            m_fv = 1'b1;
            m_words.delete();
            m_in = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) chk($sformatf("ch%0d", i), 32'(ch[i]), 32'(m_ch[i]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("slot", 32'(slot), 32'(m_words.size()));
    chk("busy", 32'(busy), 32'(m_in));
    chk("pulse_excl", 32'(frame_valid & frame_err), 32'd0);
  end

  task automatic send(input bit s, input logic [W-1:0] d);
    @(negedge clk);
    sof = s; din = d; din_valid = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      sof = 1'b0; din_valid = 1'b0;
    end
  endtask

  task automatic frame(input logic [W-1:0] base);
    for (int i = 0; i < 8; i++) send(i == 0, base + W'(i));
  endtask

  initial begin
    // Async reset asserted mid-cycle while inputs toggle.
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 8'h55);
    send(1'b0, 8'h66);
    @(negedge clk);
    din = W'($urandom); sof = 1'($urandom); din_valid = 1'($urandom);
    #2 rst = 1'b1;
    #1;
    chk("rst_ch0", 32'(ch[0]), 32'h0);
    chk("rst_ch7", 32'(ch[7]), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    gap(1);
    rst = 1'b0;
    gap(1);

    // Single frame 0x01..0x08.
    frame(8'h01);
    gap(1);
    chk("single_ch0", 32'(ch[0]), 32'h01);
    chk("single_ch7", 32'(ch[7]), 32'h08);
    chk("single_fv", 32'(frame_valid), 32'h1);
    chk("single_busy", 32'(busy), 32'h0);
    gap(1);
    chk("single_fv_once", 32'(frame_valid), 32'h0);

    // Gapped frame: 3 idle cycles between slots 3 and 4.
    for (int i = 0; i < 4; i++) send(i == 0, 8'h01 + W'(i));
    for (int g = 0; g < 3; g++) begin
      gap(1);
      chk("gap_slot", 32'(slot), 32'h4);
      chk("gap_no_fv", 32'(frame_valid), 32'h0);
    end
    for (int i = 4; i < 8; i++) send(1'b0, 8'h01 + W'(i));
    gap(1);
    chk("gap_ch4", 32'(ch[4]), 32'h05);
    chk("gap_fv", 32'(frame_valid), 32'h1);

    // Early sof during frame A.
    for (int i = 0; i < 5; i++) send(i == 0, 8'hA0 + W'(i));
    send(1'b1, 8'hB0);
    send(1'b0, 8'hB1);
    chk("early_err", 32'(frame_err), 32'h1);
    chk("early_ch_hold", 32'(ch[0]), 32'h01);
    for (int i = 2; i < 8; i++) send(1'b0, 8'hB0 + W'(i));
    gap(1);
    chk("early_fv", 32'(frame_valid), 32'h1);
    chk("early_ch0", 32'(ch[0]), 32'hB0);
    chk("early_ch7", 32'(ch[7]), 32'hB7);

    // Stray word in IDLE, then back-to-back frames.
    send(1'b0, 8'h0F);
    gap(1);
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_slot", 32'(slot), 32'h0);
    frame(8'h10);
    frame(8'h20);
    gap(1);
    chk("b2b_fv", 32'(frame_valid), 32'h1);
    chk("b2b_ch0", 32'(ch[0]), 32'h20);
    chk("b2b_ch7", 32'(ch[7]), 32'h27);

    // Reset after slot 5 accepted, then a fresh frame.
    for (int i = 0; i < 6; i++) send(i == 0, 8'h30 + W'(i));
    @(negedge clk);
    din_valid = 1'b0; sof = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ch0", 32'(ch[0]), 32'h0);
    chk("midrst_slot", 32'(slot), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    frame(8'h40);
    gap(1);
    chk("fresh_ch3", 32'(ch[3]), 32'h43);
    chk("fresh_err", 32'(frame_err), 32'h0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      din       = W'($urandom);
      din_valid = ($urandom_range(9, 0) < 7);
      sof       = ($urandom_range(99, 0) < 15);
      if ($urandom_range(299, 0) == 0) #2 rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; sof = 1'b0;
    gap(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Time-division demultiplexer and receive-side counterpart of the team's 8:1 select tree.
- Accepts one word per slot from a serialized 8-slot frame and steers slot k to channel output k.
- Presents all eight channels together, double-buffered, once a full frame is captured.
- Sits at the far end of a link whose transmitter walks an 8:1 mux through the slots.

Parameters:
- WIDTH, 1, bits per slot word and per channel output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  slot data word.
- din_valid  input  1  din carries a slot word this cycle.
- sof  input  1  start of frame; qualifies din_valid word as slot 0.
- ch0..ch7  output  WIDTH each  registered channel outputs, slot 0..7 of last complete frame.
- frame_valid  output  1  one-cycle pulse: ch0..ch7 just updated.
- frame_err  output  1  one-cycle pulse: frame aborted by early sof.
- slot  output  3  index of next expected slot (0 in IDLE).
- busy  output  1  high while in COLLECT.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset (async, any time, including mid-frame):
  - state=IDLE, slot=0, shadow buffer and ch0..ch7 = 0.
  - frame_valid=0, frame_err=0, busy=0.
  - Partial frame discarded.
- A word is accepted only on an edge where din_valid=1. sof with din_valid=0 is ignored.
- State machine: IDLE, COLLECT.
- IDLE:
  - din_valid=1 and sof=1: shadow[0]<=din, slot<=1, go to COLLECT.
  - din_valid=1 and sof=0: word dropped, no error, stay in IDLE.
- COLLECT, din_valid=1 and sof=0:
  - shadow[slot]<=din, slot<=slot+1.
  - When slot==7: on that same edge, ch0..ch6<=shadow[0..6], ch7<=din, frame_valid<=1 (high exactly one cycle), slot<=0 (wraps), state<=IDLE.
- COLLECT, din_valid=1 and sof=1 (early sof, any slot 1..7):
  - frame_err<=1 for one cycle; partial shadow abandoned.
  - shadow[0]<=din, slot<=1, stay in COLLECT.
  - ch0..ch7 unchanged, no frame_valid.
- COLLECT, din_valid=0: hold; gaps of any length allowed between slots.
- Latency and outputs:
  - ch outputs and frame_valid change on the edge that accepts the slot-7 word; they are visible in the following cycle.
  - ch outputs hold between frames; a channel word never updates alone.
- Back-to-back frames: sof+din_valid on the cycle right after slot-7 acceptance is taken as slot 0 of the next frame. Zero-bubble throughput is 8 words per 8 cycles.
- frame_valid and frame_err are never high in the same cycle.
- slot=0 and busy=0 whenever state=IDLE.
- Fully synchronous except reset; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle with random inputs -> immediately ch0..ch7=0, slot=0, busy=0, frame_valid=0, frame_err=0.
- Single frame, WIDTH=4:
  - Stimulus: sof on the first word, words 0x1,0x2..0x8 on 8 consecutive cycles.
  - Response: one cycle after the 8th edge, ch0=0x1 .. ch7=0x8, frame_valid pulses once, busy falls.
- Gapped frame:
  - Stimulus: same words with din_valid low for 3 cycles between slots 3 and 4.
  - Response: identical ch values, frame_valid exactly once after the 8th accepted word, slot holds 4 during the gap.
- Early sof:
  - Stimulus: frame A words 0xA0.. for slots 0–4, then sof with 0xB0 and 7 more words 0xB1..0xB7.
  - Response: frame_err pulse at the 0xB0 edge, no frame_valid for A, then ch0..ch7=0xB0..0xB7 and a single frame_valid.
- Back-to-back and stray data:
  - Stimulus: din_valid without sof in IDLE (word 0xF), then two consecutive frames.
  - Response: 0xF ignored, two frame_valid pulses 8 cycles apart, second frame's values on outputs.
- Reset mid-frame:
  - Stimulus: rst after slot 5 is accepted, then a fresh full frame.
  - Response: outputs stay 0 until the fresh frame completes, no frame_err.
